// File: rtl/uart_num_sender.sv
// =============================================================================
//  Module      : uart_num_sender
//  Description : Latches a count, converts it to four ASCII decimal digits by
//                repeated subtraction and feeds them (plus optional CR LF) to
//                uart_tx over the tx_start / tx_busy handshake.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_num_sender #(
    parameter int unsigned TERM_CRLF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req_i,
    input  logic [13:0] value_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONV    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] STG_1000 = 2'd0;
    localparam logic [1:0] STG_100  = 2'd1;
    localparam logic [1:0] STG_10   = 2'd2;

    localparam logic [13:0] C_MAX_VALUE = 14'd9999;
    localparam logic [2:0]  C_LAST_IDX  = (TERM_CRLF != 0) ? 3'd5 : 3'd3;
    localparam logic [7:0]  C_ASCII_0   = 8'h30;

    logic [2:0]  state_q,    state_d;
    logic [13:0] rem_q,      rem_d;
    logic [3:0]  d3_q,       d3_d;
    logic [3:0]  d2_q,       d2_d;
    logic [3:0]  d1_q,       d1_d;
    logic [3:0]  d0_q,       d0_d;
    logic [1:0]  stage_q,    stage_d;
    logic [2:0]  char_idx_q, char_idx_d;
    logic [7:0]  tx_data_q,  tx_data_d;

    logic [13:0] w_weight;
    logic [2:0]  w_idx_next;
    logic [7:0]  w_char_next;

    always_comb begin
        case (stage_q)
            STG_1000: w_weight = 14'd1000;
            STG_100:  w_weight = 14'd100;
            default:  w_weight = 14'd10;
        endcase
    end

    // Character that follows the one currently on tx_data.
    assign w_idx_next = char_idx_q + 3'd1;

    always_comb begin
        case (w_idx_next)
            3'd1:    w_char_next = C_ASCII_0 + {4'h0, d2_q};
            3'd2:    w_char_next = C_ASCII_0 + {4'h0, d1_q};
            3'd3:    w_char_next = C_ASCII_0 + {4'h0, d0_q};
            3'd4:    w_char_next = 8'h0D;
            3'd5:    w_char_next = 8'h0A;
            default: w_char_next = C_ASCII_0 + {4'h0, d3_q};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        d3_d       = d3_q;
        d2_d       = d2_q;
        d1_d       = d1_q;
        d0_d       = d0_q;
        stage_d    = stage_q;
        char_idx_d = char_idx_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (send_req_i) begin
                    rem_d   = (value_i > C_MAX_VALUE) ? C_MAX_VALUE : value_i;
                    d3_d    = 4'd0;
                    d2_d    = 4'd0;
                    d1_d    = 4'd0;
                    d0_d    = 4'd0;
                    stage_d = STG_1000;
                    state_d = S_CONV;
                end
            end

            S_CONV: begin
                if (rem_q >= w_weight) begin
                    rem_d = rem_q - w_weight;
                    case (stage_q)
                        STG_1000: d3_d = d3_q + 4'd1;
                        STG_100:  d2_d = d2_q + 4'd1;
                        default:  d1_d = d1_q + 4'd1;
                    endcase
                end else if (stage_q == STG_10) begin
                    // Remainder is now below ten, so it is the units digit.
                    d0_d       = rem_q[3:0];
                    char_idx_d = 3'd0;
                    tx_data_d  = C_ASCII_0 + {4'h0, d3_q};
                    state_d    = S_START;
                end else begin
                    stage_d = stage_q + 2'd1;
                end
            end

            S_START: begin
                state_d = S_WAIT_HI;
            end

            // tx_busy lags tx_start by two cycles; wait for it to rise first.
            S_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = S_WAIT_LO;
                end
            end

            S_WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (char_idx_q == C_LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        char_idx_d = w_idx_next;
                        tx_data_d  = w_char_next;
                        state_d    = S_START;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_q      <= 14'd0;
            d3_q       <= 4'd0;
            d2_q       <= 4'd0;
            d1_q       <= 4'd0;
            d0_q       <= 4'd0;
            stage_q    <= STG_1000;
            char_idx_q <= 3'd0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            d3_q       <= d3_d;
            d2_q       <= d2_d;
            d1_q       <= d1_d;
            d0_q       <= d0_d;
            stage_q    <= stage_d;
            char_idx_q <= char_idx_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start_o = (state_q == S_START);
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_uart_num_sender.sv
// =============================================================================
//  Module      : tb_uart_num_sender
//  Description : Directed bench for uart_num_sender with a cycle-level
//                uart_tx handshake model for each TERM_CRLF setting.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_uart_num_sender;

    localparam int BYTE_CYC = 20;
    localparam int BUDGET   = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_req;
    logic        sel;
    logic [13:0] value;

    logic        tx_start_a, busy_a, done_a, tx_busy_a;
    logic [7:0]  tx_data_a;
    logic        tx_start_b, busy_b, done_b, tx_busy_b;
    logic [7:0]  tx_data_b;

    int          ucnt_a = 0, ucnt_b = 0;
    int          viol_a = 0, viol_b = 0;
    logic [7:0]  cap_a = 8'h00, cap_b = 8'h00;
    logic [7:0]  log_a[$];
    logic [7:0]  log_b[$];

    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    uart_num_sender #(.TERM_CRLF(1)) u_dut_crlf (
        .clk        (clk),
        .rst        (rst),
        .send_req_i (send_req && !sel),
        .value_i    (value),
        .tx_busy_i  (tx_busy_a),
        .tx_start_o (tx_start_a),
        .tx_data_o  (tx_data_a),
        .busy_o     (busy_a),
        .done_o     (done_a)
    );

    uart_num_sender #(.TERM_CRLF(0)) u_dut_raw (
        .clk        (clk),
        .rst        (rst),
        .send_req_i (send_req && sel),
        .value_i    (value),
        .tx_busy_i  (tx_busy_b),
        .tx_start_o (tx_start_b),
        .tx_data_o  (tx_data_b),
        .busy_o     (busy_b),
        .done_o     (done_b)
    );

    // uart_tx model: busy rises 2 cycles after the start cycle, lasts BYTE_CYC.
    assign tx_busy_a = (ucnt_a >= 2) && (ucnt_a < 2 + BYTE_CYC);
    assign tx_busy_b = (ucnt_b >= 2) && (ucnt_b < 2 + BYTE_CYC);

    always @(posedge clk) begin
        if (tx_start_a) begin
            ucnt_a <= 1;
            cap_a  <= tx_data_a;
            log_a.push_back(tx_data_a);
        end else if (ucnt_a == 2 + BYTE_CYC) begin
            ucnt_a <= 0;
        end else if (ucnt_a != 0) begin
            ucnt_a <= ucnt_a + 1;
        end
    end

    always @(posedge clk) begin
        if (tx_start_b) begin
            ucnt_b <= 1;
            cap_b  <= tx_data_b;
            log_b.push_back(tx_data_b);
        end else if (ucnt_b == 2 + BYTE_CYC) begin
            ucnt_b <= 0;
        end else if (ucnt_b != 0) begin
            ucnt_b <= ucnt_b + 1;
        end
    end

    // Protocol watchers: start while busy, or data moving during a byte.
    always @(negedge clk) begin
        if (!rst && tx_start_a && tx_busy_a) viol_a <= viol_a + 1;
        else if (!rst && ucnt_a != 0 && tx_data_a != cap_a) viol_a <= viol_a + 1;
    end

    always @(negedge clk) begin
        if (!rst && tx_start_b && tx_busy_b) viol_b <= viol_b + 1;
        else if (!rst && ucnt_b != 0 && tx_data_b != cap_b) viol_b <= viol_b + 1;
    end

    wire        s_start  = sel ? tx_start_b : tx_start_a;
    wire        s_busy   = sel ? busy_b     : busy_a;
    wire        s_done   = sel ? done_b     : done_a;
    wire        s_txbusy = sel ? tx_busy_b  : tx_busy_a;
    wire [7:0]  s_data   = sel ? tx_data_b  : tx_data_a;

    function automatic int log_size();
        return sel ? log_b.size() : log_a.size();
    endfunction

    function automatic logic [7:0] log_at(input int idx);
        return sel ? log_b[idx] : log_a[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: plain message, 1: extra send_req during byte 2, 2: reset during byte 3
    task automatic run_msg(input logic [13:0] v, input string exp_txt,
                           input int exp_conv, input int mode);
        int         conv, dones, cyc, base, vbase, injected, hold, nexp;
        bit         aborted;
        logic [7:0] exp_b;
        base     = log_size();
        vbase    = sel ? viol_b : viol_a;
        injected = 0;
        hold     = 0;
        aborted  = 1'b0;

        @(negedge clk);
        value    = v;
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        value    = v ^ 14'h3FFF;
        check("busy_after_accept", 32'(s_busy), 32'd1);

        conv = 0;
        while (!s_start && conv < 100) begin
            conv++;
            @(negedge clk);
        end
        check("conv_cycles", 32'(conv), 32'(exp_conv));

        dones = 0;
        cyc   = 0;
        while (s_busy && cyc < BUDGET && !aborted) begin
            send_req = 1'b0;
            if (s_done) dones++;
            if (mode == 1 && injected == 0 && log_size() - base == 3 && s_txbusy) begin
                send_req = 1'b1;
                value    = 14'd7;
                injected = 1;
            end
            if (mode == 2 && log_size() - base == 4 && s_txbusy) begin
                hold++;
                if (hold == 3) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check("rst_busy",     32'(s_busy),  32'd0);
                    check("rst_tx_start", 32'(s_start), 32'd0);
                    check("rst_done",     32'(s_done),  32'd0);
                    check("rst_tx_data",  32'(s_data),  32'h00);
                    aborted = 1'b1;
                end
            end
            if (!aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        send_req = 1'b0;

        if (mode == 2) begin
            check("abort_no_done", 32'(dones), 32'd0);
            check("abort_bytes_sent", 32'(log_size() - base), 32'd4);
        end else begin
            check("msg_in_budget", 32'(cyc < BUDGET), 32'd1);
            check("done_pulses", 32'(dones), 32'd1);
            if (mode == 1) check("inject_applied", 32'(injected), 32'd1);
            nexp = exp_txt.len() + (sel ? 0 : 2);
            check("byte_count", 32'(log_size() - base), 32'(nexp));
            for (int i = 0; i < nexp && i < log_size() - base; i++) begin
                if (i < 4)       exp_b = exp_txt[i];
                else if (i == 4) exp_b = 8'h0D;
                else             exp_b = 8'h0A;
                check($sformatf("byte%0d", i), 32'(log_at(base + i)), 32'(exp_b));
            end
            check("protocol_violations", 32'((sel ? viol_b : viol_a) - vbase), 32'd0);
        end
    endtask

    initial begin
        int k;
        rst      = 1'b1;
        send_req = 1'b0;
        sel      = 1'b0;
        value    = 14'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",     32'(busy_a),     32'd0);
        check("reset_tx_start", 32'(tx_start_a), 32'd0);
        check("reset_done",     32'(done_a),     32'd0);
        check("reset_tx_data",  32'(tx_data_a),  32'h00);
        rst = 1'b0;
        @(negedge clk);

        run_msg(14'd42,    "0042", 7,  0);
        run_msg(14'd9999,  "9999", 30, 0);
        run_msg(14'd0,     "0000", 3,  0);
        run_msg(14'd12000, "9999", 30, 0);
        run_msg(14'd42,    "0042", 7,  1);
        run_msg(14'd7,     "0007", 3,  0);
        run_msg(14'd8888,  "8888", 27, 2);

        // The in-flight byte finishes on the line; wait for the model to go idle.
        k = 0;
        while (ucnt_a != 0 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check("uart_idle_after_abort", 32'(ucnt_a), 32'd0);
        run_msg(14'd5, "0005", 3, 0);

        sel = 1'b1;
        @(negedge clk);
        run_msg(14'd1234, "1234", 9, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_num_sender.md
# uart_num_sender

Transmit sequencer that drives the `uart_tx` byte transmitter. On a send request it:
- latches a 14-bit count value (0–9999 range);
- converts it to four ASCII decimal digits by sequential repeated subtraction;
- feeds the digits, optionally followed by CR LF, to `uart_tx` one byte at a time over the `tx_start`/`tx_busy` handshake.

It sits between the counter core and `uart_tx` and is the only block allowed to drive `uart_tx` inputs.

## Interface
- `TERM_CRLF`, default 1: 1 = append 0x0D, 0x0A after the digits (6 bytes per message); 0 = digits only (4 bytes).
- `clk`  in  1: single system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `send_req`  in  1: request to send `value`; sampled only in IDLE.
- `value`  in  14: unsigned number to report; values above 9999 are clamped to 9999.
- `tx_busy`  in  1: from `uart_tx`; high while a byte is in flight.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8: byte to `uart_tx`; valid whenever `tx_start` = 1.
- `busy`  out  1: high from the cycle after a request is accepted until `done`.
- `done`  out  1: one-cycle pulse after the last byte has left `uart_tx`.

## Operation
- **States:** IDLE, CONV, START, WAIT_HI, WAIT_LO, DONE. All outputs are registered or Moore-decoded from registered state.
- **IDLE**
  - Outputs: `busy`=0, `tx_start`=0.
  - On `send_req`=1: latch `rem` = min(`value`, 9999), clear digits d3..d0, set weight stage = 1000, then go to CONV.
- **CONV:** one step per cycle, over weight stages 1000 → 100 → 10.
  - If `rem` ≥ weight: `rem` −= weight and the current digit increments; stay in the stage.
  - Otherwise: advance to the next stage.
  - After the tens stage exits: d0 = `rem[3:0]`, `char_idx` = 0, go to START.
  - CONV length is exactly d3+d2+d1+3 cycles (3 minimum, 30 maximum).
- **Character order:** index 0..3 = 0x30+d3, 0x30+d2, 0x30+d1, 0x30+d0; index 4 = 0x0D, index 5 = 0x0A. Leading zeros are sent.
- **START:**
  - `tx_start`=1 for exactly this cycle.
  - `tx_data` = char(`char_idx`).
  - Go to WAIT_HI.
- **WAIT_HI:** `tx_start`=0. Stay until `tx_busy`=1, then go to WAIT_LO.
- **WAIT_LO:** stay until `tx_busy`=0.
  - If `char_idx` == last (3, or 5 when `TERM_CRLF`=1), go to DONE.
  - Otherwise increment `char_idx` and go to START.
- **DONE:** `done`=1 for one cycle, `busy` still 1, then go to IDLE.
- **`tx_data`:** updated only on entry to START; held stable through WAIT_HI and WAIT_LO.
- **`send_req` outside IDLE:** ignored. It is not queued and does not alter the latched value.
- **`value`:** may change freely after the accepting cycle.

## Timing
- **Reset values:** state = IDLE, `tx_start`=0, `tx_data`=0x00, `busy`=0, `done`=0; all counters and digits = 0.
- **Reset mid-operation:** all outputs reach reset values at the first edge with `rst`=1. No partial byte is restarted.
- **Accept latency:** `send_req` sampled high at edge k → CONV and `busy`=1 from k+1.
- **`uart_tx` handshake:**
  - `tx_busy` rises 2 cycles after the `tx_start` cycle.
  - `tx_busy` falls 1 cycle after `uart_tx` returns to its idle state.
  - WAIT_HI must bridge that gap. `tx_busy`=0 in the cycle after START must not be treated as byte-complete.
- **Spacing:** `tx_start` is never asserted while `tx_busy`=1. Each byte's START follows the previous byte's `tx_busy` fall by exactly 1 cycle.
- **Message length:** CONV cycles + N × (1 + 2 + byte time + 1) + 1. N = 4 or 6; byte time = 160 `b_tick` periods.
- **Stuck `tx_busy`:** no timeout. A `tx_busy` stuck high holds WAIT_LO indefinitely; only `rst` recovers.

## Test plan
Bench: real `uart_tx` plus a 16× `b_tick` generator, and a serial monitor decoding `tx`.

1. `value`=42, `TERM_CRLF`=1 → bytes 0x30,0x30,0x34,0x32,0x0D,0x0A in order. CONV = 7 cycles. One `done` pulse; `busy` is high throughout.
2. `value`=9999 → "9999"+CRLF, CONV = 30 cycles. `value`=0 → "0000"+CRLF, CONV = 3 cycles.
3. `value`=12000 → clamped; bytes 0x39 ×4, 0x0D, 0x0A.
4. `TERM_CRLF`=0, `value`=1234 → exactly 4 bytes 0x31..0x34, then `done`. Check `tx_start` is never high while `tx_busy`=1 and `tx_data` is stable from START to WAIT_LO exit.
5. Second `send_req` with `value`=7 pulsed during byte 2 of a 42 message → still exactly "0042"+CRLF, single `done`. Next idle request with `value`=7 → "0007"+CRLF.
6. `rst` asserted for 1 cycle during WAIT_LO of byte 3 → next edge gives `busy`=0, `tx_start`=0, `done`=0. A subsequent request with `value`=5 → "0005"+CRLF, correct.
